// File: rtl/fft_uart_streamer_pkg.sv
// Shared constants and state encoding for the FFT frame to UART packet streamer.
package fft_uart_pkg;

    localparam logic [7:0] SYNC0 = 8'hA5;
    localparam logic [7:0] SYNC1 = 8'h5A;

    localparam logic MODE_RAW = 1'b0;
    localparam logic MODE_MAG = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StHdr0,
        StHdr1,
        StPayload,
        StCsum
    } state_e;

endpackage

// File: rtl/fft_uart_streamer_if.sv
// Sample stream from the FFT: one complex sample per valid cycle, last marks end of frame.
interface fft_uart_streamer_if #(
    parameter int unsigned DATA_W = 14
) ();

    logic                     s_valid;
    logic signed [DATA_W-1:0] s_re;
    logic signed [DATA_W-1:0] s_im;
    logic                     s_last;

    modport master (output s_valid, s_re, s_im, s_last);
    modport slave  (input  s_valid, s_re, s_im, s_last);

endinterface

// File: rtl/fft_uart_streamer_uart_tx_byte.sv
// 8N1 UART transmitter: a byte issued on start goes out from the next cycle, LSB first.
module uart_tx_byte #(
    parameter int unsigned BIT_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int unsigned CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    logic [CNT_W-1:0] cyc_q;
    logic [3:0]       bit_q;
    logic [8:0]       shift_q;
    logic             busy_q;
    logic             tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '1;
            busy_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else if (!busy_q) begin
            if (start) begin
                busy_q  <= 1'b1;
                tx_q    <= 1'b0;
                shift_q <= {1'b1, data};
                cyc_q   <= '0;
                bit_q   <= '0;
            end
        end else if (cyc_q == CNT_W'(BIT_CYC - 1)) begin
            cyc_q <= '0;
            // bit_q counts completed bits; the tenth is the stop bit
            if (bit_q == 4'd9) begin
                busy_q <= 1'b0;
                tx_q   <= 1'b1;
            end else begin
                tx_q    <= shift_q[0];
                shift_q <= {1'b1, shift_q[8:1]};
                bit_q   <= bit_q + 4'd1;
            end
        end else begin
            cyc_q <= cyc_q + CNT_W'(1);
        end
    end

    assign busy = busy_q;
    assign tx   = tx_q;

endmodule

// File: rtl/fft_uart_streamer.sv
// Buffers whole FFT frames in a FIFO and sends each as a checksummed UART packet,
// either raw re/im or |re|+|im| magnitude, gated per packet by the host's rx_ready.
module fft_uart_streamer
    import fft_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115_200,
    parameter int unsigned DATA_W     = 14,
    parameter int unsigned FRAME_LEN  = 1024,
    parameter int unsigned FIFO_DEPTH = 2048
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mode,
    fft_uart_streamer_if.slave  s,
    input  logic                rx_ready,
    output logic                tx_ready,
    output logic                tx,
    output logic [7:0]          drop_cnt
);

    localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
    localparam int unsigned ADDR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned ENTRY_W = 2 * DATA_W + 1;

    typedef logic [ADDR_W:0] ptr_t;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];

    ptr_t       wr_ptr_q, rd_ptr_q, pending_q, pending_d, count, free;
    logic       in_frame_q, in_frame_d, accept_q, accept_d;
    logic       frame_start, admit, wr_en, pop;
    logic [7:0] drop_q, drop_d;

    state_e     state_q, state_d;
    logic       mode_q, mode_d;
    logic [7:0] csum_q, csum_d;
    logic [1:0] byte_idx_q, byte_idx_d;

    logic                     uart_start, uart_busy;
    logic [7:0]               uart_data;
    logic [ENTRY_W-1:0]       head;
    logic                     head_last;
    logic signed [DATA_W-1:0] head_re, head_im;
    logic [DATA_W-1:0]        re_abs, im_abs;
    logic [DATA_W:0]          mag;
    logic [15:0]              re16, im16, mag16;
    logic [7:0]               pay_byte;
    logic [1:0]               last_idx;

    // Admission is decided once per frame, at its first valid sample.
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        free        = ptr_t'(FIFO_DEPTH) - count;
        frame_start = s.s_valid && !in_frame_q;
        admit       = frame_start ? (free >= ptr_t'(FRAME_LEN)) : accept_q;
        wr_en       = s.s_valid && admit;
        in_frame_d  = in_frame_q;
        accept_d    = accept_q;
        drop_d      = drop_q;
        if (s.s_valid) begin
            in_frame_d = !s.s_last;
            accept_d   = admit;
        end
        if (frame_start && !admit && drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {s.s_last, s.s_re, s.s_im};
        end
    end

    always_comb begin
        head      = mem[rd_ptr_q[ADDR_W-1:0]];
        head_last = head[ENTRY_W-1];
        head_re   = head[2*DATA_W-1:DATA_W];
        head_im   = head[DATA_W-1:0];
        re16      = 16'(head_re);
        im16      = 16'(head_im);
        re_abs    = head_re[DATA_W-1] ? unsigned'(-head_re) : unsigned'(head_re);
        im_abs    = head_im[DATA_W-1] ? unsigned'(-head_im) : unsigned'(head_im);
        mag       = {1'b0, re_abs} + {1'b0, im_abs};
        mag16     = 16'(mag);
        last_idx  = (mode_q == MODE_MAG) ? 2'd1 : 2'd3;
        if (mode_q == MODE_MAG) begin
            pay_byte = byte_idx_q[0] ? mag16[7:0] : mag16[15:8];
        end else begin
            case (byte_idx_q)
                2'd0:    pay_byte = re16[15:8];
                2'd1:    pay_byte = re16[7:0];
                2'd2:    pay_byte = im16[15:8];
                default: pay_byte = im16[7:0];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        csum_d     = csum_q;
        byte_idx_d = byte_idx_q;
        uart_start = 1'b0;
        uart_data  = 8'h00;
        pop        = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pending_q != '0 && rx_ready && !uart_busy) begin
                    state_d    = StHdr0;
                    mode_d     = mode;
                    csum_d     = 8'h00;
                    byte_idx_d = 2'd0;
                end
            end
            StHdr0: begin
                uart_data = SYNC0;
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_d    = StHdr1;
                end
            end
            StHdr1: begin
                uart_data = SYNC1;
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_d    = StPayload;
                end
            end
            StPayload: begin
                uart_data = pay_byte;
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    csum_d     = csum_q ^ pay_byte;
                    if (byte_idx_q == last_idx) begin
                        byte_idx_d = 2'd0;
                        pop        = 1'b1;
                        if (head_last) begin
                            state_d = StCsum;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                    end
                end
            end
            StCsum: begin
                uart_data = csum_q;
                if (!uart_busy) begin
                    uart_start = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pending_d = pending_q + ptr_t'(wr_en && s.s_last) - ptr_t'(pop && head_last);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pending_q  <= '0;
            in_frame_q <= 1'b0;
            accept_q   <= 1'b0;
            drop_q     <= 8'h00;
            state_q    <= StIdle;
            mode_q     <= MODE_RAW;
            csum_q     <= 8'h00;
            byte_idx_q <= 2'd0;
        end else begin
            wr_ptr_q   <= wr_ptr_q + ptr_t'(wr_en);
            rd_ptr_q   <= rd_ptr_q + ptr_t'(pop);
            pending_q  <= pending_d;
            in_frame_q <= in_frame_d;
            accept_q   <= accept_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    uart_tx_byte #(
        .BIT_CYC (BIT_CYC)
    ) u_uart (
        .clk   (clk),
        .rst_n (rst_n),
        .start (uart_start),
        .data  (uart_data),
        .busy  (uart_busy),
        .tx    (tx)
    );

    assign tx_ready = (state_q == StIdle) && !uart_busy;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fft_uart_streamer.sv
// Directed bench: decodes the serial line mid-bit and checks packets, flow control,
// frame dropping, mid-packet input changes and asynchronous reset.
module tb_fft_uart_streamer;

    localparam int unsigned DATA_W = 14;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       rx_ready = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic [7:0] drop_cnt;

    int     vectors = 0;
    int     miscompares = 0;
    bit     dead = 1'b0;
    longint t_start = 0;
    longint t0 = 0;

    fft_uart_streamer_if #(.DATA_W(DATA_W)) s_if ();

    fft_uart_streamer #(
        .CLK_FREQ   (1_600_000),
        .BAUD       (100_000),
        .DATA_W     (DATA_W),
        .FRAME_LEN  (4),
        .FIFO_DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .s        (s_if),
        .rx_ready (rx_ready),
        .tx_ready (tx_ready),
        .tx       (tx),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int re, input int im, input logic last);
        @(negedge clk);
        s_if.s_valid = 1'b1;
        s_if.s_re    = DATA_W'(re);
        s_if.s_im    = DATA_W'(im);
        s_if.s_last  = last;
    endtask

    task automatic frame(input int r0, input int i0, input int r1, input int i1,
                         input int r2, input int i2, input int r3, input int i3);
        drive(r0, i0, 1'b0);
        drive(r1, i1, 1'b0);
        drive(r2, i2, 1'b0);
        drive(r3, i3, 1'b1);
    endtask

    task automatic stop_in();
        @(negedge clk);
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
    endtask

    // Returns at the first negedge inside a start bit; gives up after a bounded wait.
    task automatic wait_start();
        int n = 0;
        if (dead) return;
        do begin
            @(negedge clk);
            n++;
        end while (tx !== 1'b0 && n < 3000);
        if (tx !== 1'b0) begin
            chk("start_timeout", 32'd0, 32'd1);
            dead = 1'b1;
        end
        t_start = longint'($time);
    endtask

    task automatic recv_byte(output logic [7:0] b);
        b = 'x;
        wait_start();
        if (dead) return;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            b[i] = tx;
        end
        repeat (16) @(negedge clk);
        if (tx !== 1'b1) chk("stop_bit", {31'd0, tx}, 32'd1);
    endtask

    task automatic expect_pkt(input string tag, input logic [191:0] bytes, input int n);
        logic [7:0] b;
        for (int i = 0; i < n; i++) begin
            recv_byte(b);
            chk($sformatf("%s[%0d]", tag, i), {24'd0, b}, {24'd0, bytes[8*(n-1-i) +: 8]});
        end
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        logic ok = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        logic [7:0] b;
        s_if.s_valid = 1'b0;
        s_if.s_re    = '0;
        s_if.s_im    = '0;
        s_if.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
        rst_n = 1'b1;

        // Raw frame
        rx_ready = 1'b1;
        mode     = 1'b0;
        frame(1, 0, -1, 2, 8191, -2, -8192, 0);
        stop_in();
        recv_byte(b);
        t0 = t_start;
        chk("raw_hdr0", {24'd0, b}, 32'hA5);
        chk("busy_tx_ready", {31'd0, tx_ready}, 32'd0);
        recv_byte(b);
        chk("raw_hdr1", {24'd0, b}, 32'h5A);
        chk("byte_period", 32'(t_start - t0), 32'd1610);
        expect_pkt("raw", 192'h0001_0000_FFFF_0002_1FFF_FFFE_E000_0000_02, 17);
        repeat (20) @(negedge clk);
        chk("done_tx_ready", {31'd0, tx_ready}, 32'd1);

        // Magnitude frame
        mode = 1'b1;
        frame(-3, 4, -8192, -8192, 0, 0, 5, 0);
        stop_in();
        expect_pkt("mag", 192'hA55A_0007_4000_0000_0005_42, 11);
        repeat (20) @(negedge clk);

        // Host flow control
        rx_ready = 1'b0;
        mode     = 1'b0;
        frame(2, 0, 0, 0, 0, 0, 0, 1);
        stop_in();
        expect_idle("fc_hold", 400);
        chk("fc_tx_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge clk);
        rx_ready = 1'b1;
        @(posedge clk);
        #1 chk("fc_lat1", {31'd0, tx}, 32'd1);
        @(posedge clk);
        #1 chk("fc_lat2", {31'd0, tx}, 32'd0);
        expect_pkt("fc", 192'hA55A_0002_0000_0000_0000_0000_0000_0000_0001_03, 19);
        repeat (20) @(negedge clk);

        // Three back-to-back frames into an 8-entry FIFO: third is dropped
        rx_ready = 1'b0;
        mode     = 1'b1;
        frame(1, 0, 0, 0, 0, 0, 0, 0);
        frame(0, -2, 0, 0, 0, 0, 0, 0);
        frame(3, 0, 0, 0, 0, 0, 0, 0);
        stop_in();
        chk("drop_cnt", {24'd0, drop_cnt}, 32'd1);
        rx_ready = 1'b1;
        expect_pkt("drop_a", 192'hA55A_0001_0000_0000_0000_01, 11);
        expect_pkt("drop_b", 192'hA55A_0002_0000_0000_0000_02, 11);
        expect_idle("drop_no_third", 400);
        chk("drop_cnt_after", {24'd0, drop_cnt}, 32'd1);

        // Mode and rx_ready change during payload
        mode     = 1'b0;
        rx_ready = 1'b1;
        frame(256, 0, 0, 0, 0, 0, 0, -1);
        stop_in();
        expect_pkt("mid_head", 192'hA55A_01, 3);
        mode     = 1'b1;
        rx_ready = 1'b0;
        expect_pkt("mid_tail", 192'h0000_00_0000_0000_0000_0000_0000_FFFF_01, 16);
        frame(7, -1, 0, 0, 0, 0, 0, 0);
        stop_in();
        expect_idle("mid_hold", 400);
        rx_ready = 1'b1;
        expect_pkt("mid_next", 192'hA55A_0008_0000_0000_0000_08, 11);
        repeat (20) @(negedge clk);

        // Asynchronous reset during a data bit of the second header byte
        mode = 1'b0;
        frame(2, 0, 0, 0, 0, 0, 0, 1);
        stop_in();
        recv_byte(b);
        chk("rst_hdr0", {24'd0, b}, 32'hA5);
        wait_start();
        repeat (16) @(negedge clk);
        chk("rst_in_bit", {31'd0, tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_tx", {31'd0, tx}, 32'd1);
        chk("async_drop", {24'd0, drop_cnt}, 32'd0);
        chk("async_tx_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        expect_idle("rst_residual", 400);
        frame(2, 0, 0, 0, 0, 0, 0, 1);
        stop_in();
        expect_pkt("rst_fresh", 192'hA55A_0002_0000_0000_0000_0000_0000_0000_0001_03, 19);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
